// File: rtl/axi_rd_pkg.sv
// ---------------------------------------------------------------------------
// axi_rd_pkg
// Shared types and encodings for the AXI read-channel scheduler.
//   rd_state_t  : scheduler FSM state (IDLE / AR / R)
//   BURST_*     : AXI arburst encodings
//   SIZE_WORD   : arsize code used for line refills (4 bytes per beat)
//   ar_size_code: arsize for a request (line refill or single beat)
// ---------------------------------------------------------------------------
package axi_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } rd_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_WORD   = 3'b010;

    // Line refills always move full words; single reads use the requester's size.
    function automatic logic [2:0] ar_size_code(input logic burst, input logic [1:0] size);
        return burst ? SIZE_WORD : {1'b0, size};
    endfunction

endpackage

// File: rtl/rd_grant_arb.sv
// ---------------------------------------------------------------------------
// rd_grant_arb
// Picks one requester for the read channel.
// Build option: AXI_RD_SCHED_RR_EN
//   defined   : round-robin, search starts at an internal pointer which moves
//               to (grantee + 1) mod NUM_REQ on every taken grant.
//   undefined : fixed priority, lowest index wins, no pointer register.
// Ports:
//   clk, reset : clock / synchronous active-high reset (pointer only)
//   req        : request vector
//   en         : a grant is permitted this cycle
//   adv        : grant is being taken, advance the pointer
//   gnt        : one-hot grant (zero when en is low or no request)
//   gnt_idx    : binary index of the grantee
//   gnt_any    : a grant is issued this cycle
// ---------------------------------------------------------------------------
module rd_grant_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic               adv,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic found;

`ifdef AXI_RD_SCHED_RR_EN
    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // (ptr + k) mod NUM_REQ without a divider
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
        if (!en) begin
            gnt = '0;
        end
        gnt_any = found & en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end
`else
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
        if (!en) begin
            gnt = '0;
        end
        gnt_any = found & en;
    end

    // Fixed priority keeps no state.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset, adv};
`endif

endmodule

// File: rtl/axi_rd_sched.sv
// ---------------------------------------------------------------------------
// axi_rd_sched
// Shares one AXI AR/R port between NUM_REQ cache read requesters. Grants one
// requester at a time, drives registered AR signals, tracks a single
// outstanding burst, routes R beats to its owner and checks the beat count
// against rlast.
// Build option: AXI_RD_SCHED_RR_EN selects round-robin arbitration
// (default: fixed priority, index 0 highest).
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   req_valid/addr/size/burst/len : per-requester read request (sliced)
//   req_ready                  : one-hot, AR handshake done for that requester
//   ret_valid/ret_last/ret_data: R beat routed to the owner
//   wr_idle                    : write engine idle, gates new grants
//   rd_idle                    : scheduler in IDLE
//   proto_err                  : sticky burst-length mismatch flag
//   ar*/arready, r*/rready     : AXI read address / data channels
//
// state | meaning
// ------+----------------------------------------
// IDLE  | no read in flight
// AR    | arvalid held, waiting for arready
// R     | rready high, collecting beats until rlast
// ---------------------------------------------------------------------------
module axi_rd_sched
    import axi_rd_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int LEN_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*32-1:0]    req_addr,
    input  logic [NUM_REQ*2-1:0]     req_size,
    input  logic [NUM_REQ-1:0]       req_burst,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       ret_valid,
    output logic [NUM_REQ-1:0]       ret_last,
    output logic [31:0]              ret_data,
    input  logic                     wr_idle,
    output logic                     rd_idle,
    output logic                     proto_err,
    output logic [3:0]               arid,
    output logic [31:0]              araddr,
    output logic [LEN_W-1:0]         arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [1:0]               arlock,
    output logic [3:0]               arcache,
    output logic [2:0]               arprot,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [3:0]               rid,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    rd_state_t          state, state_nx;
    logic [IDX_W-1:0]   own;
    logic [LEN_W:0]     beat_cnt;

    logic               r_beat, r_end, ar_done, grant_en;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;

    logic [31:0]        sel_addr;
    logic [1:0]         sel_size;
    logic               sel_burst;
    logic [LEN_W-1:0]   sel_len;

    assign r_beat  = (state == R) & rvalid;
    assign r_end   = r_beat & rlast;
    assign ar_done = (state == AR) & arready;
    // A burst ending this cycle frees the port, so the next grant can be
    // taken on the same edge without passing through IDLE.
    assign grant_en = wr_idle & ((state == IDLE) | r_end);

    rd_grant_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .en      (grant_en),
        .adv     (gnt_any),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_size  = '0;
        sel_burst = 1'b0;
        sel_len   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr  = req_addr[i*32 +: 32];
                sel_size  = req_size[i*2 +: 2];
                sel_burst = req_burst[i];
                sel_len   = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (gnt_any) state_nx = AR;
            AR:      if (arready) state_nx = R;
            R:       if (r_end)   state_nx = gnt_any ? AR : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        ret_valid = '0;
        ret_last  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (own == IDX_W'(i)) begin
                req_ready[i] = ar_done;
                ret_valid[i] = r_beat;
                ret_last[i]  = r_end;
            end
        end
    end

    assign ret_data = rdata;
    assign rready   = (state == R);
    assign rd_idle  = (state == IDLE);

    assign arid    = '0;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            own       <= '0;
            arvalid   <= 1'b0;
            araddr    <= '0;
            arlen     <= '0;
            arsize    <= '0;
            arburst   <= '0;
            beat_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nx;

            if (r_beat) begin
                // Saturate rather than wrap so a runaway burst stays flagged.
                if (beat_cnt != '1) begin
                    beat_cnt <= beat_cnt + (LEN_W+1)'(1);
                end
                // Early rlast, or the beat that should have been last is not.
                if ((rlast && (beat_cnt != {1'b0, arlen})) ||
                    (!rlast && (beat_cnt == {1'b0, arlen}))) begin
                    proto_err <= 1'b1;
                end
            end

            if (gnt_any) begin
                own      <= gnt_idx;
                arvalid  <= 1'b1;
                araddr   <= sel_addr;
                arlen    <= sel_burst ? sel_len : '0;
                arsize   <= ar_size_code(sel_burst, sel_size);
                arburst  <= sel_burst ? BURST_INCR : BURST_FIXED;
                beat_cnt <= '0;
            end else if (ar_done) begin
                arvalid <= 1'b0;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, rid, rresp};

endmodule
